// File: rtl/dccm_ctrl_pkg.sv
// Shared constants and response type for the DCCM responder and its return pipeline.
package dccm_ctrl_pkg;

    localparam int              XLEN            = 32;
    localparam logic [XLEN-1:0] DEF_DCCM_BASE   = 32'h0001_0000;
    localparam int              DEF_DCCM_WORDS  = 4096;
    localparam int              DEF_DCCM_RD_LAT = 2;
    localparam int              DCCM_IDX_W      = $clog2(DEF_DCCM_WORDS);

    typedef struct packed {
        logic            valid;
        logic            err;
        logic [XLEN-1:0] data;
    } dccm_rsp_t;

endpackage

// File: rtl/dccm_ctrl_if.sv
// Point-to-point DCCM read/write bus between the LSU (master) and the DCCM controller (slave).
interface dccm_ctrl_if
    import dccm_ctrl_pkg::*;
    ;

    logic [XLEN-1:0] dccm_raddr;
    logic            dccm_rvalid_in;
    logic [XLEN-1:0] dccm_rdata;
    logic            dccm_rvalid_out;
    logic            dccm_rerr;
    logic [XLEN-1:0] dccm_waddr;
    logic            dccm_wen;
    logic [XLEN-1:0] dccm_wdata;
    logic            dccm_werr;

    modport master (
        output dccm_raddr, dccm_rvalid_in, dccm_waddr, dccm_wen, dccm_wdata,
        input  dccm_rdata, dccm_rvalid_out, dccm_rerr, dccm_werr
    );

    modport slave (
        input  dccm_raddr, dccm_rvalid_in, dccm_waddr, dccm_wen, dccm_wdata,
        output dccm_rdata, dccm_rvalid_out, dccm_rerr, dccm_werr
    );

endinterface

// File: rtl/dccm_ctrl_ram.sv
// 1R1W synchronous data array with registered read and write-first bypass; drop-in point for an SRAM macro.
module dccm_ram #(
    parameter int WORDS  = 4096,
    parameter int IDX_W  = $clog2(WORDS),
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [DATA_W-1:0] mem_q [WORDS];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: neither the storage nor the read register is reset, so this maps onto a macro;
    // the controller masks rdata_o until a valid in-range read has landed.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dccm_ctrl.sv
// DCCM responder: range check, write-error pulse and a fixed-latency read-return pipeline around dccm_ram.
module dccm_ctrl
    import dccm_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] DCCM_BASE  = DEF_DCCM_BASE,
    parameter int              DCCM_WORDS = DEF_DCCM_WORDS,
    parameter int              RD_LAT     = DEF_DCCM_RD_LAT
) (
    input logic        clk,
    input logic        rst_n,
    dccm_ctrl_if.slave bus
);

    localparam int            IDX_W = $clog2(DCCM_WORDS);
    localparam logic [XLEN:0] LO    = {1'b0, DCCM_BASE};
    localparam logic [XLEN:0] HI    = LO + ((XLEN+1)'(DCCM_WORDS) << 2);

    // One extra bit keeps the upper bound from wrapping at the top of the address space.
    function automatic logic in_range(input logic [XLEN-1:0] addr);
        return ({1'b0, addr} >= LO) && ({1'b0, addr} < HI);
    endfunction

    logic             r_in, w_in;
    logic             ram_re, ram_we;
    logic [IDX_W-1:0] ridx, widx;
    logic [XLEN-1:0]  ram_rdata;
    logic             s0_valid_q, s0_err_q, werr_q;
    dccm_rsp_t        s0_rsp, out_rsp;

    assign r_in = in_range(bus.dccm_raddr);
    assign w_in = in_range(bus.dccm_waddr);

    // The base is aligned to the window size, so the word index is just the low address bits.
    assign ridx = bus.dccm_raddr[IDX_W+1:2];
    assign widx = bus.dccm_waddr[IDX_W+1:2];

    assign ram_re = bus.dccm_rvalid_in & r_in;
    assign ram_we = bus.dccm_wen & w_in & rst_n;

    dccm_ram #(
        .WORDS  (DCCM_WORDS),
        .IDX_W  (IDX_W),
        .DATA_W (XLEN)
    ) u_ram (
        .clk     (clk),
        .re_i    (ram_re),
        .raddr_i (ridx),
        .rdata_o (ram_rdata),
        .we_i    (ram_we),
        .waddr_i (widx),
        .wdata_i (bus.dccm_wdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid_q <= 1'b0;
            s0_err_q   <= 1'b0;
            werr_q     <= 1'b0;
        end else begin
            s0_valid_q <= bus.dccm_rvalid_in;
            s0_err_q   <= bus.dccm_rvalid_in & ~r_in;
            werr_q     <= bus.dccm_wen & ~w_in;
        end
    end

    always_comb begin
        s0_rsp.valid = s0_valid_q;
        s0_rsp.err   = s0_err_q;
        s0_rsp.data  = (s0_valid_q && !s0_err_q) ? ram_rdata : '0;
    end

    generate
        if (RD_LAT == 1) begin : g_direct
            assign out_rsp = s0_rsp;
        end else begin : g_pipe
            dccm_rsp_t pipe_q [RD_LAT-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < RD_LAT-1; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else begin
                    pipe_q[0] <= s0_rsp;
                    for (int i = 1; i < RD_LAT-1; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign out_rsp = pipe_q[RD_LAT-2];
        end
    endgenerate

    assign bus.dccm_rvalid_out = out_rsp.valid;
    assign bus.dccm_rerr       = out_rsp.err;
    assign bus.dccm_rdata      = out_rsp.data;
    assign bus.dccm_werr       = werr_q;

endmodule
